mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the CPU data bus (wr_en, mem_addr, w_data, r_data). It serialises CPU-written bytes onto an 8N1 UART line.
- It holds one byte in a holding register while another byte shifts out.
- The top level uses sel to choose r_data from this block instead of the RAM, and to suppress the RAM write.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte address of register 0; must be 16-byte aligned.
- DEFAULT_DIV, 16'd868, reset value of BAUD_DIV in clk_en ticks per bit (100 MHz / 115200).

Ports:
- clk_100M  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- clk_en  in  1  tick enable; all state updates are qualified by it
- wr_en  in  1  CPU store strobe
- mem_addr  in  32  CPU byte address
- w_data  in  32  CPU store data
- r_data  out  32  register read data; zero when not selected
- sel  out  1  combinational; high when mem_addr[31:4]==BASE_ADDR[31:4]
- tx  out  1  serial line; idles high
- irq  out  1  level; high while the holding register is empty and IRQ_EN=1

Behaviour:
- Reset: rst_n=0 sampled on a clk_100M edge takes effect regardless of clk_en. Reset values:
  - tx=1, r_data=0, irq=0
  - FSM in IDLE, hold_full=0, overrun=0
  - BAUD_DIV=DEFAULT_DIV, IRQ_EN=0
- Register map, by offset mem_addr[3:0]:
  - 0x0 TXDATA. A write enqueues w_data[7:0]. A read returns 0.
  - 0x4 STATUS, read-only. bit0 busy (FSM not IDLE), bit1 hold_full, bit2 ready (=!hold_full), bit3 overrun; other bits 0. A STATUS read clears overrun.
  - 0x8 BAUD_DIV, R/W. Uses [15:0]; a written 0 is stored as 1.
  - 0xC CTRL, R/W. bit0 IRQ_EN.
  - Unaligned offsets (mem_addr[1:0]!=0) and non-word offsets: reads return 0, writes are ignored.
- Bus timing:
  - A write takes effect on the clk_en edge where sel & wr_en.
  - Reads are registered: r_data is updated on each clk_en edge from the address presented. This is one-tick latency, matching the RAM.
  - r_data is 0 when sel=0.
  - Read side effects (overrun clear) occur only when sel & !wr_en & offset==0x4.
- Holding register:
  - A TXDATA write with hold_full=0 stores the byte and sets hold_full.
  - A TXDATA write with hold_full=1 drops the byte and sets overrun, except when the holding register is being transferred to the shifter on that same tick. In that case the new byte is accepted and hold_full stays 1.
- Baud counter:
  - 16 bits. Loaded with BAUD_DIV-1 at each bit start; decremented per clk_en; a bit ends at 0.
  - A BAUD_DIV write mid-frame takes effect at the next bit start.
- FSM states:
  - IDLE: tx=1. If hold_full: shift_reg<=hold, hold_full<=0, go to START.
  - START: tx=0 for one bit period, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx], LSB first, 8 bit periods. After bit_idx==7 go to STOP.
  - STOP: tx=1 for one bit period. Then, if hold_full, load and go directly to START with no idle gap; else go to IDLE.
- Frame length is exactly 10*BAUD_DIV clk_en ticks. tx is registered and glitch-free.
- irq = IRQ_EN & !hold_full, registered.
- Reset mid-frame aborts the frame: tx=1 on the next edge, and the held byte is discarded.
- Ticks with clk_en=0 freeze all state, including the counter.

Test Plan:
1. Reset, BAUD_DIV=4, write 0xA5 to BASE+0x0 -> tx: start 0 for 4 ticks, then 1,0,1,0,0,1,0,1 (4 ticks each), then stop 1. STATUS reads 0x5 mid-frame and 0x4 after the frame.
2. Back-to-back: write 0x01, then 0x02 immediately, then a third byte 0x03 while hold_full -> frames 0x01 and 0x02 are sent with no idle gap; 0x03 is dropped. STATUS=0x8|busy bits; the next STATUS read returns bit3=0.
3. Write BAUD_DIV=0 -> reads back 1; each bit lasts 1 tick, and the frame is 10 ticks.
4. CTRL=1 -> irq=1 while idle; irq=0 one tick after a TXDATA write; irq=1 once the byte moves to the shifter.
5. Access 0xFFFF_0010 and 0x0000_0004 -> sel=0, r_data=0, no state change. Write to BASE+0x2 -> ignored.
6. Assert rst_n=0 during DATA bit 3 -> tx=1 next edge; STATUS=0x4; BAUD_DIV returns to 868.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register.
// Registers: TXDATA (0x0), STATUS (0x4), BAUD_DIV (0x8), CTRL (0xC).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        overrun_q, overrun_d;
    logic [15:0] div_q, div_d;
    logic        irq_en_q, irq_en_d;
    logic        tx_q, tx_d;
    logic        irq_q;
    logic [31:0] r_data_q, r_data_d;

    logic [3:0]  offset;
    logic        wr_tx, wr_div, wr_ctrl, rd_status;
    logic        bit_end, load;
    logic        unused_wdata;

    assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = mem_addr[3:0];
    assign wr_tx     = sel & wr_en & (offset == 4'h0);
    assign wr_div    = sel & wr_en & (offset == 4'h8);
    assign wr_ctrl   = sel & wr_en & (offset == 4'hC);
    assign rd_status = sel & ~wr_en & (offset == 4'h4);
    assign bit_end   = (cnt_q == 16'd0);
    // Holding register moves to the shifter when idle or as the stop bit ends.
    assign load      = hold_full_q & ((state_q == StIdle) | ((state_q == StStop) & bit_end));
    assign unused_wdata = ^w_data[31:16];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    cnt_d     = div_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            shift_d = hold_q;
            state_d = StStart;
            cnt_d   = div_q - 16'd1;
        end
    end

    always_comb begin
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        div_d       = div_q;
        irq_en_d    = irq_en_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (wr_tx) begin
            if (!hold_full_q || load) begin
                hold_d      = w_data[7:0];
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (rd_status) begin
            overrun_d = 1'b0;
        end
        if (wr_div) begin
            div_d = (w_data[15:0] == 16'd0) ? 16'd1 : w_data[15:0];
        end
        if (wr_ctrl) begin
            irq_en_d = w_data[0];
        end
    end

    always_comb begin
        r_data_d = 32'd0;
        if (sel) begin
            case (offset)
                4'h4:    r_data_d = {28'd0, overrun_q, ~hold_full_q, hold_full_q,
                                     state_q != StIdle};
                4'h8:    r_data_d = {16'd0, div_q};
                4'hC:    r_data_d = {31'd0, irq_en_q};
                default: r_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            div_q       <= DEFAULT_DIV;
            irq_en_q    <= 1'b0;
            tx_q        <= 1'b1;
            irq_q       <= 1'b0;
            r_data_q    <= 32'd0;
        end else if (clk_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            div_q       <= div_d;
            irq_en_q    <= irq_en_d;
            tx_q        <= tx_d;
            irq_q       <= irq_en_q & ~hold_full_q;
            r_data_q    <= r_data_d;
        end
    end

    assign tx     = tx_q;
    assign irq    = irq_q;
    assign r_data = r_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] w_data = 32'd0;
    logic [31:0] r_data;
    logic        sel, tx, irq;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk_100M(clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .wr_en   (wr_en),
        .mem_addr(mem_addr),
        .w_data  (w_data),
        .r_data  (r_data),
        .sel     (sel),
        .tx      (tx),
        .irq     (irq)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit check_on = 1'b0;

    // Reference model: a frame is a list of 10 line levels, each held for the
    // divisor in force when that bit begins.
    logic        m_busy;
    logic [9:0]  m_bits;
    int          m_pos, m_rem;
    logic        m_hold_full, m_ovr, m_irq_en, m_irq;
    logic [7:0]  m_hold;
    int          m_div;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_bits = 10'h3FF; m_pos = 0; m_rem = 0;
        m_hold_full = 1'b0; m_hold = 8'd0; m_ovr = 1'b0;
        m_div = 868; m_irq_en = 1'b0; m_irq = 1'b0; m_rdata = 32'd0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic s, xfer, hf_pre, en_pre;
        logic [3:0] o;
        int div_pre;
        s = (a[31:4] == BASE[31:4]);
        o = a[3:0];
        hf_pre = m_hold_full; en_pre = m_irq_en; div_pre = m_div;
        m_rdata = 32'd0;
        if (s) begin
            case (o)
                4'h4: m_rdata = {28'd0, m_ovr, !m_hold_full, m_hold_full, m_busy};
                4'h8: m_rdata = {16'd0, m_div[15:0]};
                4'hC: m_rdata = {31'd0, m_irq_en};
                default: m_rdata = 32'd0;
            endcase
        end
        m_irq = en_pre & !hf_pre;
        xfer = hf_pre && (!m_busy || (m_pos == 9 && m_rem == 1));
        if (m_busy) begin
            if (m_rem > 1) m_rem--;
            else if (m_pos == 9) m_busy = 1'b0;
            else begin m_pos++; m_rem = div_pre; end
        end
        if (xfer) begin
            m_bits = {1'b1, m_hold, 1'b0};
            m_pos = 0; m_rem = div_pre; m_busy = 1'b1; m_hold_full = 1'b0;
        end
        if (s && w && o == 4'h0) begin
            if (!hf_pre || xfer) begin m_hold = d[7:0]; m_hold_full = 1'b1; end
            else m_ovr = 1'b1;
        end
        if (s && !w && o == 4'h4) m_ovr = 1'b0;
        if (s && w && o == 4'h8) m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
        if (s && w && o == 4'hC) m_irq_en = d[0];
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("tx", {31'd0, tx}, {31'd0, m_busy ? m_bits[m_pos] : 1'b1});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("r_data", r_data, m_rdata);
        end
    end

    task automatic step(input logic rst, input logic en, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst_n = rst; clk_en = en; wr_en = w; mem_addr = a; w_data = d;
        #1 chk("sel", {31'd0, sel}, {31'd0, a[31:4] == BASE[31:4]});
        @(posedge clk);
        if (!rst) model_reset();
        else if (en) model_step(w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b1, a, d);
    endtask
    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    initial begin
        logic [9:0] fr;
        logic [31:0] a, d;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_on = 1'b1;
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset r_data", r_data, 32'd0);

        // 0xA5 at four ticks per bit
        wr(BASE + 32'h8, 32'd4);
        wr(BASE + 32'h0, 32'hA5);
        fr = 10'b1_1010_0101_0;
        for (int k = 1; k <= 41; k++) begin
            if (k == 20) begin
                rd(BASE + 32'h4);
                chk("status mid-frame", r_data, 32'h5);
            end else begin
                idle(1);
            end
            if (k <= 40) chk("a5 frame tx", {31'd0, tx}, {31'd0, fr[(k - 1) / 4]});
            else chk("a5 after frame tx", {31'd0, tx}, 32'd1);
        end
        rd(BASE + 32'h4);
        chk("status after frame", r_data, 32'h4);

        // back-to-back frames and overrun
        wr(BASE, 32'h01);
        wr(BASE, 32'h02);
        wr(BASE, 32'h03);
        rd(BASE + 32'h4);
        chk("status overrun", r_data, 32'hB);
        rd(BASE + 32'h4);
        chk("status overrun cleared", r_data, 32'h3);
        idle(36);
        chk("frame1 stop bit", {31'd0, tx}, 32'd1);
        idle(1);
        chk("frame2 starts without gap", {31'd0, tx}, 32'd0);
        idle(45);
        rd(BASE + 32'h4);
        chk("status after two frames", r_data, 32'h4);

        // divisor 0 stored as 1
        wr(BASE + 32'h8, 32'd0);
        rd(BASE + 32'h8);
        chk("baud_div zero reads 1", r_data, 32'd1);
        wr(BASE, 32'h3C);
        fr = 10'b1_0011_1100_0;
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            chk("div1 frame tx", {31'd0, tx}, {31'd0, fr[k - 1]});
        end
        idle(1);
        rd(BASE + 32'h4);
        chk("status after 10-tick frame", r_data, 32'h4);

        // interrupt level
        wr(BASE + 32'hC, 32'd1);
        idle(1);
        chk("irq idle enabled", {31'd0, irq}, 32'd1);
        rd(BASE + 32'hC);
        chk("ctrl readback", r_data, 32'd1);
        wr(BASE, 32'h55);
        chk("irq on write tick", {31'd0, irq}, 32'd1);
        idle(1);
        chk("irq low while held", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq high after transfer", {31'd0, irq}, 32'd1);
        idle(12);

        // out-of-window and misaligned accesses
        rd(32'hFFFF_0010);
        chk("other window sel", {31'd0, sel}, 32'd0);
        chk("other window r_data", r_data, 32'd0);
        rd(32'h0000_0004);
        chk("low addr r_data", r_data, 32'd0);
        wr(32'hFFFF_0018, 32'd7);
        wr(BASE + 32'h2, 32'h77);
        wr(BASE + 32'hA, 32'd5);
        rd(BASE + 32'h4);
        chk("misaligned write ignored", r_data, 32'h4);
        rd(BASE + 32'h8);
        chk("baud unchanged", r_data, 32'd1);

        // reset during DATA bit 3 with a byte held
        wr(BASE + 32'h8, 32'd4);
        wr(BASE, 32'hC3);
        wr(BASE, 32'h99);
        idle(17);
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("mid-frame reset tx", {31'd0, tx}, 32'd1);
        chk("mid-frame reset irq", {31'd0, irq}, 32'd0);
        rd(BASE + 32'h4);
        chk("status after reset", r_data, 32'h4);
        rd(BASE + 32'h8);
        chk("baud after reset", r_data, 32'd868);

        // randomized traffic with small divisors
        wr(BASE + 32'h8, 32'd2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE | 32'($urandom_range(0, 15));
            d = $urandom;
            if (a[3:0] == 4'h8) d = 32'($urandom_range(0, 5));
            step($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0, a, d);
        end

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
